ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer for a single-port synchronous RAM with a registered read.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first) instead of round-robin.
module ram_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req/we/addr/wdata stable until it sees its one-cycle gnt;
    // a req still high when the FSM is back in IDLE counts as a fresh command. rvalid is a
    // one-cycle pulse and rdata holds until that port's next read completes.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam int              CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                id_q;
    logic                gnt0_q, gnt1_q;
    logic                rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;

    logic                any_req_d;
    logic                win_d;

    assign any_req_d = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign win_d = ~req0;
`else
    logic ptr_q;

    assign win_d = (req0 && req1) ? ptr_q : req1;

    // The favoured port becomes whichever one was not just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (state_q == IDLE && any_req_d) begin
            ptr_q <= ~win_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        id_q       <= win_d;
                        gnt0_q     <= ~win_d;
                        gnt1_q     <= win_d;
                        ram_we_q   <= win_d ? we1 : we0;
                        ram_addr_q <= win_d ? addr1 : addr0;
                        ram_data_q <= win_d ? wdata1 : wdata0;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM samples the command on the edge that leaves this state.
                    ram_we_q <= 1'b0;
                    if (ram_we_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (cnt_q == '0) begin
                        if (id_q) begin
                            rdata1_q  <= ram_q;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= ram_q;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset/contention sequences and random traffic
// checked against a transaction-level model of arbitration, RAM contents and timing.
module tb_ram_arbiter;
  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int RL  = 3;
  localparam int TMO = 200;
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             gap;
  } cmd_t;

  typedef struct {
    bit             port;
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  cmd_t cq0[$];
  cmd_t cq1[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int due_q0[$];
  int due_q1[$];
  int grant_log[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Behavioural RAM: registered read with RL cycles of latency.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] pipe [RL];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RL-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_mem [64];
  bit m_ptr = 1'b0;
  bit m_idle = 1'b1;
  int busy_left = 0;
  int cyc = 0;
  logic [DW-1:0] m_rdata0 = '0, m_rdata1 = '0;
  bit p_req0 = 1'b0, p_req1 = 1'b0, p_we0 = 1'b0, p_we1 = 1'b0;
  logic [AW-1:0] p_addr0 = '0, p_addr1 = '0;
  logic [DW-1:0] p_wd0 = '0, p_wd1 = '0;

  always @(negedge clk) begin : monitor
    bit w, exp_g, g_we, exp_rv;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    cyc++;
    if (!rst_n) begin
      m_ptr = 1'b0; m_idle = 1'b1; busy_left = 0;
      m_rdata0 = '0; m_rdata1 = '0;
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    end else begin
      exp_g = m_idle && (p_req0 || p_req1);
      chk("gnt_pulse", 32'(gnt0 | gnt1), 32'(exp_g));
      chk("gnt_both", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0 || gnt1) begin
        if (p_req0 && p_req1) w = FIXED ? 1'b0 : m_ptr;
        else w = p_req1;
        chk("gnt_winner", 32'(gnt1), 32'(w));
        g_we   = w ? p_we1 : p_we0;
        g_addr = w ? p_addr1 : p_addr0;
        g_wd   = w ? p_wd1 : p_wd0;
        chk("ram_we", 32'(ram_we), 32'(g_we));
        chk("ram_addr", 32'(ram_addr), 32'(g_addr));
        if (g_we) begin
          chk("ram_data", 32'(ram_data), 32'(g_wd));
          m_mem[g_addr] = g_wd;
          busy_left = 1;
        end else begin
          if (w) begin exp_q1.push_back(m_mem[g_addr]); due_q1.push_back(cyc + RL + 1); end
          else begin exp_q0.push_back(m_mem[g_addr]); due_q0.push_back(cyc + RL + 1); end
          busy_left = RL + 1;
        end
        m_ptr = ~w;
        grant_log.push_back(int'(w));
      end else begin
        chk("ram_we_idle", 32'(ram_we), 32'd0);
      end
      chk("busy", 32'(busy), 32'(busy_left != 0));
      m_idle = (busy_left == 0);
      if (busy_left > 0) busy_left--;

      exp_rv = (due_q0.size() > 0) && (due_q0[0] == cyc);
      chk("rvalid0", 32'(rvalid0), 32'(exp_rv));
      if (exp_rv) begin void'(due_q0.pop_front()); m_rdata0 = exp_q0.pop_front(); end
      chk("rdata0", 32'(rdata0), 32'(m_rdata0));
      exp_rv = (due_q1.size() > 0) && (due_q1[0] == cyc);
      chk("rvalid1", 32'(rvalid1), 32'(exp_rv));
      if (exp_rv) begin void'(due_q1.pop_front()); m_rdata1 = exp_q1.pop_front(); end
      chk("rdata1", 32'(rdata1), 32'(m_rdata1));
    end
    p_req0 = req0; p_req1 = req1; p_we0 = we0; p_we1 = we1;
    p_addr0 = addr0; p_addr1 = addr1; p_wd0 = wdata0; p_wd1 = wdata1;
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input bit p, input bit r, input cmd_t c);
    if (p) begin req1 = r; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata; end
    else begin req0 = r; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata; end
  endtask

  task automatic drive_port(input bit p);
    cmd_t c;
    bit got;
    while ((p ? cq1.size() : cq0.size()) != 0) begin
      if (p) c = cq1.pop_front();
      else c = cq0.pop_front();
      repeat (c.gap) @(posedge clk);
      #1 set_port(p, 1'b1, c);
      got = 1'b0;
      for (int t = 0; t < TMO; t++) begin
        @(negedge clk);
        if (p ? gnt1 : gnt0) begin got = 1'b1; break; end
      end
      chk("gnt_wait", 32'(got), 32'd1);
      @(posedge clk);
      #1 set_port(p, 1'b0, c);
    end
  endtask

  task automatic do_op(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.gap = 0;
    if (p) cq1.push_back(c);
    else cq0.push_back(c);
    drive_port(p);
    repeat (RL + 3) @(posedge clk);
    #1;
  endtask

  task automatic reset_now_check();
    rst_n = 1'b0;
    #1;
    chk("rst_flags", 32'({gnt0, gnt1, rvalid0, rvalid1, ram_we, busy}), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset_now_check();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t vecs[7];
    int exp_order[8];
    cmd_t c;
    bit got;

    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    vecs[0] = '{1'b0, 1'b1, 6'h05, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 6'h05, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 6'h3F, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 6'h00, 8'hC3, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 6'h3F, 8'h00, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 6'h00, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 6'h00, 8'h00, 8'hC3};
    for (int i = 0; i < 8; i++) exp_order[i] = FIXED ? int'(i >= 4) : (i % 2);

    apply_reset();
    repeat (2) @(posedge clk);
    #1;

    // Directed vector table: single write, cross-port read-back, boundary addresses.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].we)
        chk("vec_rdata", 32'(vecs[i].port ? rdata1 : rdata0), 32'(vecs[i].exp_rdata));
    end

    // Reset in the middle of a read: everything clears at once, no late rvalid.
    c.we = 1'b0; c.addr = 6'h05; c.wdata = 8'h00; c.gap = 0;
    cq0.push_back(c);
    fork drive_port(1'b0); join_none
    got = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk);
      if (gnt0) begin got = 1'b1; break; end
    end
    chk("midrd_gnt", 32'(got), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 reset_now_check();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    do_op(1'b1, 1'b1, 6'h2A, 8'h5D);
    do_op(1'b0, 1'b0, 6'h2A, 8'h00);
    chk("post_rst_rdata0", 32'(rdata0), 32'h5D);

    // Contention: preload, reset the pointer, then both ports stream reads.
    for (int i = 0; i < 8; i++)
      do_op(i[0], 1'b1, AW'(6'h10 + i), DW'($urandom_range(0, 255)));
    apply_reset();
    #1;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      c.we = 1'b0; c.wdata = '0; c.gap = 0;
      c.addr = AW'(6'h10 + 2*i);     cq0.push_back(c);
      c.addr = AW'(6'h10 + 2*i + 1); cq1.push_back(c);
    end
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join
    repeat (RL + 4) @(posedge clk);
    #1;
    chk("grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) chk("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Random traffic on both ports against the model.
    for (int i = 0; i < 30; i++) begin
      c.we = 1'($urandom_range(0, 1)); c.addr = AW'($urandom_range(0, 63));
      c.wdata = DW'($urandom_range(0, 255)); c.gap = int'($urandom_range(0, 3));
      cq0.push_back(c);
      c.we = 1'($urandom_range(0, 1)); c.addr = AW'($urandom_range(0, 63));
      c.wdata = DW'($urandom_range(0, 255)); c.gap = int'($urandom_range(0, 3));
      cq1.push_back(c);
    end
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join
    repeat (RL + 4) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
